// File: rtl/sram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_ctrl
// Description : Single-port SRAM bank controller. Arbitrates one write and
//               one read port onto a row-wide array with byte enables.
//               Mode 0 accesses one word of a row; mode 1 accesses the same
//               byte position across every word of a row (strided). Read
//               data returns in order through a first-word-fall-through
//               response FIFO, protected by a credit scheme.
// Ports       : clk, rst            clock, async active-high reset
//               wr_vld/wr_rdy       write handshake (wr_addr/lane/mode/data)
//               rd_vld/rd_rdy       read handshake  (rd_addr/lane/mode)
//               rsp_vld/rsp_rdy     response handshake (rsp_data)
//               conflict_cnt        saturating count of wr/rd collisions
// Revision    : 1.0  initial release
// ============================================================================
module sram_bank_ctrl #(
    parameter int WORD_W    = 32,
    parameter int LANES     = 4,
    parameter int ADDR_W    = 9,
    parameter int STARVE    = 3,
    parameter int RSP_DEPTH = 2,
    localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_vld,
    output logic              wr_rdy,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LW-1:0]     wr_lane,
    input  logic              wr_mode,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_vld,
    output logic              rd_rdy,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LW-1:0]     rd_lane,
    input  logic              rd_mode,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [WORD_W-1:0] rsp_data,
    output logic [15:0]       conflict_cnt
);

    localparam int NBW   = WORD_W / 8;              // bytes per word
    localparam int ROW_W = LANES * WORD_W;
    localparam int ROW_B = ROW_W / 8;
    localparam int NB    = (LANES < NBW) ? LANES : NBW; // strided byte count
    localparam int SW    = $clog2(STARVE + 1);
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [SW-1:0] c_STARVE = SW'(STARVE);
    localparam logic [CW-1:0] c_DEPTH  = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] c_LAST   = PW'(RSP_DEPTH - 1);

    // Storage (not reset)
    logic [ROW_W-1:0]  r_mem  [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] r_fifo [0:RSP_DEPTH-1];
    logic [ROW_W-1:0]  r_rd_row;
    logic [LW-1:0]     r_rd_lane;
    logic              r_rd_mode;

    // Control state (reset)
    logic              r_inflight;
    logic [SW-1:0]     r_wait;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [15:0]       r_conflict;

    logic              w_credit_ok;
    logic              w_starved;
    logic              w_rd_pref;
    logic              w_rd_go;
    logic              w_wr_go;
    logic              w_push;
    logic              w_pop;
    logic [ROW_B-1:0]  w_be;
    logic [ROW_W-1:0]  w_wrow;
    logic [WORD_W-1:0] w_rsp_word;

    // ------------------------------------------------------------------
    // Arbitration. Credit counts the FIFO slots not yet promised to a
    // response; a read is only offered when one is free. When no credit
    // is left the write simply goes ahead.
    // ------------------------------------------------------------------
    assign w_credit_ok = (r_count + CW'(r_inflight)) < c_DEPTH;
    assign w_starved   = (r_wait == c_STARVE);
    assign w_rd_pref   = w_credit_ok && (!wr_vld || w_starved);

    assign rd_rdy  = !rst && w_rd_pref;
    assign wr_rdy  = !rst && !(rd_vld && w_rd_pref);
    assign w_rd_go = rd_vld && rd_rdy;
    assign w_wr_go = wr_vld && wr_rdy;

    // ------------------------------------------------------------------
    // Write byte-enable / row data generation
    // ------------------------------------------------------------------
    always_comb begin
        w_be   = '0;
        w_wrow = '0;
        if (!wr_mode) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_lane == LW'(l)) begin
                    w_be[l*NBW +: NBW]      = '1;
                    w_wrow[l*WORD_W +: WORD_W] = wr_data;
                end
            end
        end else begin
            // Data byte k lands in byte wr_lane of word k.
            for (int k = 0; k < NB; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    if ((l < NBW) && (wr_lane == LW'(l))) begin
                        w_be[k*NBW + l]              = 1'b1;
                        w_wrow[(k*NBW + l)*8 +: 8]   = wr_data[k*8 +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Array and FIFO storage. The read captures the row and its lane/mode
    // so extraction happens in the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            for (int b = 0; b < ROW_B; b++) begin
                if (w_be[b]) begin
                    r_mem[wr_addr][b*8 +: 8] <= w_wrow[b*8 +: 8];
                end
            end
        end
        if (w_rd_go) begin
            r_rd_row  <= r_mem[rd_addr];
            r_rd_lane <= rd_lane;
            r_rd_mode <= rd_mode;
        end
        if (w_push) begin
            r_fifo[r_wptr] <= w_rsp_word;
        end
    end

    // ------------------------------------------------------------------
    // Read data extraction from the captured row
    // ------------------------------------------------------------------
    always_comb begin
        w_rsp_word = '0;
        if (!r_rd_mode) begin
            for (int l = 0; l < LANES; l++) begin
                if (r_rd_lane == LW'(l)) begin
                    w_rsp_word = r_rd_row[l*WORD_W +: WORD_W];
                end
            end
        end else begin
            for (int k = 0; k < NB; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    if ((l < NBW) && (r_rd_lane == LW'(l))) begin
                        w_rsp_word[k*8 +: 8] = r_rd_row[(k*NBW + l)*8 +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign w_push   = r_inflight;
    assign rsp_vld  = (r_count != '0);
    assign w_pop    = rsp_vld && rsp_rdy;
    assign rsp_data = rsp_vld ? r_fifo[r_rptr] : '0;

    assign conflict_cnt = r_conflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_wait     <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_conflict <= '0;
        end else begin
            r_inflight <= w_rd_go;

            if (w_push) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Starvation counter only ages while the read could have been
            // served, i.e. it lost to a write with credit available.
            if (!rd_vld || w_rd_go) begin
                r_wait <= '0;
            end else if (w_credit_ok && !w_starved) begin
                r_wait <= r_wait + 1'b1;
            end

            if (wr_vld && rd_vld && (r_conflict != 16'hFFFF)) begin
                r_conflict <= r_conflict + 16'd1;
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == c_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_sram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bank_ctrl
// Description : Scoreboard bench for sram_bank_ctrl. Stimulus pushes the
//               hand-computed response of each accepted read into a queue;
//               an independent monitor pops and compares on every response
//               transfer. Inputs change 1 time unit after the rising edge,
//               all sampling happens on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_bank_ctrl;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    localparam int ADDR_W = 9;
    localparam int LW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_vld, wr_rdy, wr_mode;
    logic [ADDR_W-1:0] wr_addr;
    logic [LW-1:0]     wr_lane;
    logic [WORD_W-1:0] wr_data;
    logic              rd_vld, rd_rdy, rd_mode;
    logic [ADDR_W-1:0] rd_addr;
    logic [LW-1:0]     rd_lane;
    logic              rsp_vld, rsp_rdy;
    logic [WORD_W-1:0] rsp_data;
    logic [15:0]       conflict_cnt;

    sram_bank_ctrl #(
        .WORD_W(WORD_W), .LANES(LANES), .ADDR_W(ADDR_W),
        .STARVE(3), .RSP_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr),
        .wr_lane(wr_lane), .wr_mode(wr_mode), .wr_data(wr_data),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
        .rd_lane(rd_lane), .rd_mode(rd_mode),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("rsp_hold_vld", 32'(rsp_vld), 32'd1);
                check("rsp_hold_data", rsp_data, prev_data);
            end
            if (!rsp_vld) begin
                check("rsp_data_idle", rsp_data, 32'd0);
            end
            if (rsp_vld && rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
                end else begin
                    check("rsp_data", rsp_data, exp_q.pop_front());
                end
            end
            prev_stall = rsp_vld && !rsp_rdy;
            prev_data  = rsp_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_vld = 1'b0;
        rd_vld = 1'b0;
    endtask

    task automatic do_write(input int a, input int lane, input bit mode, input logic [31:0] d);
        bit ok = 1'b0;
        next_cycle();
        wr_vld = 1'b1; wr_addr = ADDR_W'(a); wr_lane = LW'(lane);
        wr_mode = mode; wr_data = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_rdy) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_timeout: got no wr_rdy expected accept");
        end
    endtask

    task automatic do_read(input int a, input int lane, input bit mode, input logic [31:0] e);
        bit ok = 1'b0;
        next_cycle();
        rd_vld = 1'b1; rd_addr = ADDR_W'(a); rd_lane = LW'(lane); rd_mode = mode;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_rdy) begin ok = 1'b1; exp_q.push_back(e); break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_timeout: got no rd_rdy expected accept");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] row5 [4];
    int          idx;

    initial begin
        row5[0] = 32'h11111111; row5[1] = 32'h22222222;
        row5[2] = 32'hDEADBEEF; row5[3] = 32'h44444444;

        rst = 1'b1; rsp_rdy = 1'b1;
        wr_vld = 1'b1; rd_vld = 1'b1;
        wr_addr = '0; wr_lane = '0; wr_mode = 1'b0; wr_data = '0;
        rd_addr = '0; rd_lane = '0; rd_mode = 1'b0;

        // Reset state, with both requests asserted
        repeat (3) @(negedge clk);
        check("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        check("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_conflict", 32'(conflict_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wr_vld = 1'b0; rd_vld = 1'b0;

        // Mode-0 round trip with neighbouring lanes intact
        do_write(5, 0, 1'b0, row5[0]);
        do_write(5, 1, 1'b0, row5[1]);
        do_write(5, 3, 1'b0, row5[3]);
        do_write(5, 2, 1'b0, row5[2]);
        for (int l = 0; l < 4; l++) do_read(5, l, 1'b0, row5[l]);

        // Mode-1 round trip
        for (int l = 0; l < 4; l++) do_write(7, l, 1'b0, 32'h0);
        do_write(7, 1, 1'b1, 32'h44332211);
        do_read(7, 0, 1'b0, 32'h00001100);
        do_read(7, 1, 1'b1, 32'h44332211);
        do_read(7, 3, 1'b0, 32'h00004400);
        do_read(7, 0, 1'b1, 32'h00000000);

        // Read immediately after write to the same row
        do_write(3, 0, 1'b0, 32'hCAFEF00D);
        do_read(3, 0, 1'b0, 32'hCAFEF00D);
        next_cycle();
        drain();

        // Conflict / starvation: reads win on cycles 4 and 8
        do_write(10, 0, 1'b0, 32'h0A0A0A0A);
        next_cycle();
        drain();
        next_cycle();
        wr_vld = 1'b1; wr_addr = 10; wr_lane = 1; wr_mode = 1'b0; wr_data = 32'h12345678;
        rd_vld = 1'b1; rd_addr = 10; rd_lane = 0; rd_mode = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("arb_cycle%0d", c), {30'd0, wr_rdy, rd_rdy},
                  (c % 4 == 0) ? 32'd1 : 32'd2);
            if (rd_rdy) exp_q.push_back(32'h0A0A0A0A);
            @(posedge clk); #1;
        end
        wr_vld = 1'b0; rd_vld = 1'b0;
        @(negedge clk);
        check("conflict_cnt_10", 32'(conflict_cnt), 32'd10);
        drain();

        // Backpressure: only two reads fit while responses are stalled
        next_cycle();
        rsp_rdy = 1'b0;
        idx = 0;
        rd_vld = 1'b1; rd_addr = 5; rd_lane = 0; rd_mode = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 6) begin
                check("bp_accepted_stalled", 32'(idx), 32'd2);
                check("bp_rd_rdy_low", 32'(rd_rdy), 32'd0);
            end
            if (rd_vld && rd_rdy) begin
                exp_q.push_back(row5[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) rd_lane = LW'(idx);
            else         rd_vld = 1'b0;
            if (cyc == 7) rsp_rdy = 1'b1;
            if (idx == 4 && cyc > 7) break;
        end
        rd_vld = 1'b0; rsp_rdy = 1'b1;
        check("bp_accepted_total", 32'(idx), 32'd4);
        drain();

        // Reset mid-operation drops the queued response
        next_cycle();
        rsp_rdy = 1'b0;
        rd_vld = 1'b1; rd_addr = 5; rd_lane = 2; rd_mode = 1'b0;
        @(negedge clk);
        check("rst_mid_rd_accept", 32'(rd_rdy), 32'd1);
        @(posedge clk); #1;
        rd_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_mid_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; rsp_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_rsp_vld", 32'(rsp_vld), 32'd0);
        end
        check("post_rst_conflict", 32'(conflict_cnt), 32'd0);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_cmp++; n_bad++;
        $display("FAIL global_timeout: got no finish expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_bank_ctrl.md
SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WORD_W 32: port word width; multiple of 8.
  LANES 4: words per SRAM row; LANES*8 == WORD_W is required for strided mode.
  ADDR_W 9: row address width.
  STARVE 3: consecutive lost-arbitration cycles before a read is forced through.
  RSP_DEPTH 2: response FIFO depth; at least 2.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning). LW below is clog2(LANES).
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  wr_vld  in  1  write request valid.
  wr_rdy  out  1  write accepted this cycle.
  wr_addr  in  ADDR_W  write row.
  wr_lane  in  LW  word index (mode 0) or byte index (mode 1).
  wr_mode  in  1  0 = contiguous word; 1 = strided byte.
  wr_data  in  WORD_W  write data.
  rd_vld  in  1  read request valid.
  rd_rdy  out  1  read accepted this cycle.
  rd_addr  in  ADDR_W  read row.
  rd_lane  in  LW  read word or byte index.
  rd_mode  in  1  read mode.
  rsp_vld  out  1  response valid.
  rsp_rdy  in  1  response consumed.
  rsp_data  out  WORD_W  read data.
  conflict_cnt  out  16  saturating count of cycles with wr_vld and rd_vld both high.

Function
REQ-003 The block SHALL contain a single-port array of 2^ADDR_W rows of LANES*WORD_W bits, with byte write enables and 1-cycle read latency; array contents are not reset.
REQ-004 A request SHALL transfer only when vld and rdy are both high in the same cycle; at most one request (write or read) transfers per cycle.
REQ-005 Mode 0 write SHALL write wr_data to word wr_lane of the row; all other bytes are unchanged.
REQ-006 Mode 1 write SHALL write wr_data byte k to byte wr_lane of word k, for each k in 0..LANES-1; all other bytes are unchanged.
REQ-007 Mode 0 read SHALL return word rd_lane of the row.
REQ-008 Mode 1 read SHALL return, in rsp_data byte k, byte rd_lane of word k, for each k.
REQ-009 Arbitration SHALL be:
  - write wins by default;
  - read wins when wait_cnt == STARVE;
  - wait_cnt increments, saturating at STARVE, in each cycle rd_vld is high and the read is not accepted;
  - wait_cnt clears to 0 on read acceptance or when rd_vld is low.
REQ-010 rd_rdy SHALL be high only when credit > 0, where credit = RSP_DEPTH - FIFO occupancy - reads in flight.
REQ-011 When rd_vld is high but credit == 0, a pending write SHALL proceed, and wait_cnt SHALL NOT increment.
REQ-012 An accepted read SHALL enter the response FIFO in the cycle after acceptance; rsp_vld is high no earlier than 1 cycle after rd_vld&&rd_rdy.
REQ-013 Responses SHALL be returned in request order.
REQ-014 The response FIFO SHALL be first-word-fall-through.
REQ-015 rsp_data SHALL be held stable while rsp_vld && !rsp_rdy.
REQ-016 The response FIFO SHALL never overflow; overflow is a design error and is flagged by an assertion.
REQ-017 A read accepted in the cycle after a write to the same row SHALL return the post-write data.
REQ-018 conflict_cnt SHALL increment in each cycle with wr_vld && rd_vld, irrespective of rdy, and SHALL saturate at 16'hFFFF.
REQ-019 rsp_data SHALL be driven to 0 when rsp_vld is low.

Reset
REQ-020 While rst is high, outputs SHALL be:
  - wr_rdy, rd_rdy, rsp_vld = 0;
  - rsp_data = 0;
  - conflict_cnt = 0.
REQ-021 Internal state SHALL clear on reset: wait_cnt, FIFO pointers and occupancy, in-flight flag.
REQ-022 Reset asserted mid-operation SHALL drop any in-flight read and all queued responses, with no response emitted after reset releases.
REQ-023 wr_rdy and rd_rdy SHALL be permitted high from the first rising edge after rst deasserts.

Verification
REQ-024 Mode-0 round trip: write row 5, lane 2, data 0xDEADBEEF; then read row 5, lane 2, mode 0 -> rsp_data = 0xDEADBEEF; the other lanes of row 5 are unchanged.
REQ-025 Mode-1 round trip: first write row 7, lanes 0-3, mode 0, data 0x0; then write row 7, lane 1, mode 1, data 0x44332211.
  - Read row 7, lane 0, mode 0 -> 0x00001100.
  - Read row 7, lane 1, mode 1 -> 0x44332211.
REQ-026 Conflict/starvation: hold wr_vld and rd_vld high for 10 cycles with STARVE=3 -> writes are accepted 3 cycles, then the read is accepted on cycle 4; the pattern repeats; conflict_cnt = 10.
REQ-027 Backpressure: hold rsp_rdy = 0 and issue 4 reads with RSP_DEPTH=2 -> exactly 2 reads are accepted and rd_rdy falls; release rsp_rdy -> the remaining reads are accepted and all 4 responses arrive in order with no loss.
REQ-028 Reset mid-operation: assert rst 1 cycle after a read is accepted -> rsp_vld stays 0 after release, and conflict_cnt = 0.
REQ-029 Read-after-write: write row 3 at cycle N, then read row 3 at cycle N+1 -> the response carries the new data.
